frame_capture: RTL

- Receive-side sink for the FFT test-data stream interface (data_real/data_img/valid/start/over).
- Captures one frame of complex samples into an internal buffer, reporting sample count, overflow and a real-part checksum.
- Replays the frame on a valid/ready output port for FFT-core loading or result comparison in benches.

---
 rtl/frame_capture.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/frame_capture.sv
// Frame capture sink: stores one frame of complex samples, reports count,
// overflow and a real-part checksum, then replays the frame over valid/ready.
module frame_capture #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_W-1:0]              in_real,
    input  logic [DATA_W-1:0]              in_img,
    input  logic                           in_valid,
    input  logic                           in_start,
    input  logic                           in_over,
    output logic                           busy,
    output logic [DEPTH_LOG2:0]            sample_cnt,
    output logic                           overflow,
    output logic [DATA_W+DEPTH_LOG2-1:0]   sum_real,
    output logic [DATA_W-1:0]              out_real,
    output logic [DATA_W-1:0]              out_img,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           frame_done
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = DATA_W + DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_READOUT = 2'd2;

    logic [2*DATA_W-1:0]   mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_W-1:0]     out_real_q, out_real_d;
    logic [DATA_W-1:0]     out_img_q, out_img_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [2*DATA_W-1:0]   wr_data;
    logic [2*DATA_W-1:0]   rd_word;
    logic                  load_out;
    logic                  start_frame;
    logic                  capturing;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        ovf_d        = ovf_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;
        wr_addr      = wr_ptr_q;
        wr_data      = {in_real, in_img};
        load_out     = 1'b0;

        start_frame = in_start && (state_q != ST_READOUT);
        capturing   = start_frame || (state_q == ST_CAPTURE);

        if (start_frame) begin
            state_d  = ST_CAPTURE;
            wr_ptr_d = '0;
            cnt_d    = '0;
            sum_d    = '0;
            ovf_d    = 1'b0;
        end

        // Count never exceeds DEPTH, so its MSB alone flags a full buffer.
        if (capturing && in_valid) begin
            if (!cnt_d[DEPTH_LOG2]) begin
                mem_we   = 1'b1;
                wr_addr  = wr_ptr_d;
                wr_ptr_d = wr_ptr_d + 1'b1;
                cnt_d    = cnt_d + 1'b1;
                sum_d    = sum_d + SUM_W'(in_real);
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (state_q == ST_CAPTURE && !in_start && in_over) begin
            if (cnt_d != '0) begin
                state_d     = ST_READOUT;
                rd_ptr_d    = '0;
                load_out    = 1'b1;
                out_valid_d = 1'b1;
                out_last_d  = (cnt_d == 1);
            end else begin
                state_d      = ST_IDLE;
                frame_done_d = 1'b1;
            end
        end

        if (state_q == ST_READOUT && out_valid_q && out_ready) begin
            if (out_last_q) begin
                state_d      = ST_IDLE;
                out_valid_d  = 1'b0;
                out_last_d   = 1'b0;
                frame_done_d = 1'b1;
            end else begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                load_out   = 1'b1;
                out_last_d = ({1'b0, rd_ptr_d} == cnt_q - 1'b1);
            end
        end
    end

    // A one-sample frame writes index 0 on the same cycle it is first read.
    always_comb begin
        rd_word    = (mem_we && wr_addr == rd_ptr_d) ? wr_data : mem[rd_ptr_d];
        out_real_d = load_out ? rd_word[2*DATA_W-1:DATA_W] : out_real_q;
        out_img_d  = load_out ? rd_word[DATA_W-1:0] : out_img_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            out_real_q   <= '0;
            out_img_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            ovf_q        <= ovf_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            out_real_q   <= out_real_d;
            out_img_q    <= out_img_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign sample_cnt = cnt_q;
    assign overflow   = ovf_q;
    assign sum_real   = sum_q;
    assign out_real   = out_real_q;
    assign out_img    = out_img_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
endmodule
